null_symbol_frame_sequencer: RTL and testbench

Sequencing controller for the null-symbol detection datapath. Accepts the complex baseband AXI4-Stream and classifies each sample against a power threshold. A run of low-power samples within the configured length window is qualified as a null symbol. The block then gates exactly one frame of samples downstream, with frame-start and end markers. It sits between the sample front end and the symbol demodulator, and is configured by the AXI4-Lite register slave of the null symbol detector.

---
 rtl/null_symbol_frame_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_null_symbol_frame_sequencer.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/null_symbol_frame_sequencer.sv
// Null-symbol frame sequencer: finds a qualifying low-power run, then gates one frame downstream.
// Optional statistics counters are built when NSD_SEQ_STATS_EN is defined.
module null_symbol_frame_sequencer #(
   parameter int unsigned LEN_W = 16
) (
   input  logic             ACLK,
   input  logic             ARESET,
   input  logic             enable,
   input  logic [16:0]      cfg_threshold,
   input  logic [LEN_W-1:0] cfg_min_null,
   input  logic [LEN_W-1:0] cfg_max_null,
   input  logic [LEN_W-1:0] cfg_frame_len,
   input  logic [31:0]      s_axis_tdata,
   input  logic             s_axis_tvalid,
   output logic             s_axis_tready,
   output logic [31:0]      m_axis_tdata,
   output logic             m_axis_tvalid,
   input  logic             m_axis_tready,
   output logic             m_axis_tlast,
   output logic             m_axis_tuser,
   output logic             frame_start,
   output logic             null_too_long,
   output logic [1:0]       sync_state
`ifdef NSD_SEQ_STATS_EN
   ,
   output logic [31:0]      stat_frames,
   output logic [15:0]      stat_losses
`endif
);

   typedef enum logic [1:0] {
      StSearch = 2'd0,
      StNull   = 2'd1,
      StFrame  = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [LEN_W-1:0] run_cnt_q, run_cnt_d;
   logic [LEN_W-1:0] frm_cnt_q, frm_cnt_d;
   logic [LEN_W-1:0] frame_len_q, frame_len_d;
   logic             m_valid_q, m_valid_d;
   logic [31:0]      m_data_q, m_data_d;
   logic             m_user_q, m_user_d;
   logic             m_last_q, m_last_d;
   logic             frame_start_q, frame_start_d;
   logic             too_long_q, too_long_d;

   logic [16:0]      i_abs, q_abs, mag;
   logic             sample_low, s_acc;
   logic [LEN_W-1:0] run_inc, min_eff, flen_eff;

   // Negation in 17 bits so that |-32768| = 32768 is representable.
   assign i_abs = s_axis_tdata[31] ? (17'd0 - {1'b1, s_axis_tdata[31:16]})
                                   : {1'b0, s_axis_tdata[31:16]};
   assign q_abs = s_axis_tdata[15] ? (17'd0 - {1'b1, s_axis_tdata[15:0]})
                                   : {1'b0, s_axis_tdata[15:0]};
   assign mag        = i_abs + q_abs;
   assign sample_low = mag < cfg_threshold;

   assign run_inc  = (run_cnt_q == '1) ? run_cnt_q : run_cnt_q + LEN_W'(1);
   assign min_eff  = (cfg_min_null == '0) ? LEN_W'(1) : cfg_min_null;
   assign flen_eff = (cfg_frame_len == '0) ? LEN_W'(1) : cfg_frame_len;

   assign s_axis_tready = !ARESET && ((state_q != StFrame) || !m_valid_q || m_axis_tready);
   assign s_acc         = s_axis_tvalid && s_axis_tready;

   always_comb begin
      state_d       = state_q;
      run_cnt_d     = run_cnt_q;
      frm_cnt_d     = frm_cnt_q;
      frame_len_d   = frame_len_q;
      frame_start_d = 1'b0;
      too_long_d    = 1'b0;
      m_valid_d     = m_valid_q && !m_axis_tready;
      m_data_d      = m_data_q;
      m_user_d      = m_user_q;
      m_last_d      = m_last_q;

      unique case (state_q)
         StSearch: begin
            if (!enable) begin
               run_cnt_d = '0;
            end else begin
               if (s_acc) run_cnt_d = sample_low ? run_inc : '0;
               if (run_cnt_d >= min_eff) state_d = StNull;
            end
         end
         StNull: begin
            if (!enable) begin
               state_d   = StSearch;
               run_cnt_d = '0;
            end else if (s_acc) begin
               if (sample_low) begin
                  run_cnt_d = run_inc;
               end else if (run_cnt_q <= cfg_max_null) begin
                  // The terminating high sample is frame sample 0.
                  frame_start_d = 1'b1;
                  frame_len_d   = flen_eff;
                  frm_cnt_d     = LEN_W'(1);
                  m_valid_d     = 1'b1;
                  m_data_d      = s_axis_tdata;
                  m_user_d      = 1'b1;
                  m_last_d      = (flen_eff == LEN_W'(1));
                  if (flen_eff == LEN_W'(1)) begin
                     state_d   = StSearch;
                     run_cnt_d = '0;
                  end else begin
                     state_d = StFrame;
                  end
               end else begin
                  too_long_d = 1'b1;
                  run_cnt_d  = '0;
                  state_d    = StSearch;
               end
            end
         end
         StFrame: begin
            if (s_acc) begin
               m_valid_d = 1'b1;
               m_data_d  = s_axis_tdata;
               m_user_d  = 1'b0;
               m_last_d  = (frm_cnt_q == frame_len_q - LEN_W'(1));
               frm_cnt_d = frm_cnt_q + LEN_W'(1);
               if (frm_cnt_q == frame_len_q - LEN_W'(1)) begin
                  state_d   = StSearch;
                  run_cnt_d = '0;
               end
            end
         end
         default: begin
            state_d   = StSearch;
            run_cnt_d = '0;
         end
      endcase
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state_q       <= StSearch;
         run_cnt_q     <= '0;
         frm_cnt_q     <= '0;
         frame_len_q   <= '0;
         m_valid_q     <= 1'b0;
         m_data_q      <= '0;
         m_user_q      <= 1'b0;
         m_last_q      <= 1'b0;
         frame_start_q <= 1'b0;
         too_long_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         run_cnt_q     <= run_cnt_d;
         frm_cnt_q     <= frm_cnt_d;
         frame_len_q   <= frame_len_d;
         m_valid_q     <= m_valid_d;
         m_data_q      <= m_data_d;
         m_user_q      <= m_user_d;
         m_last_q      <= m_last_d;
         frame_start_q <= frame_start_d;
         too_long_q    <= too_long_d;
      end
   end

   assign m_axis_tvalid = m_valid_q;
   assign m_axis_tdata  = m_data_q;
   assign m_axis_tuser  = m_user_q;
   assign m_axis_tlast  = m_last_q;
   assign frame_start   = frame_start_q;
   assign null_too_long = too_long_q;
   assign sync_state    = state_q;

`ifdef NSD_SEQ_STATS_EN
   logic [31:0] stat_frames_q;
   logic [15:0] stat_losses_q;

   // Frames wrap; losses saturate.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         stat_frames_q <= '0;
         stat_losses_q <= '0;
      end else begin
         if (frame_start_d) stat_frames_q <= stat_frames_q + 32'd1;
         if (too_long_d && (stat_losses_q != '1)) stat_losses_q <= stat_losses_q + 16'd1;
      end
   end

   assign stat_frames = stat_frames_q;
   assign stat_losses = stat_losses_q;
`endif

endmodule

// File: tb/tb_null_symbol_frame_sequencer.sv
// Bench for null_symbol_frame_sequencer: classification table, directed scenarios and a
// randomized run checked cycle by cycle against a sample-level reference model.
module tb_null_symbol_frame_sequencer;

   logic        ACLK = 1'b0;
   logic        ARESET = 1'b1;
   logic        enable = 1'b0;
   logic [16:0] cfg_threshold = 17'd100;
   logic [15:0] cfg_min_null = 16'd4;
   logic [15:0] cfg_max_null = 16'd8;
   logic [15:0] cfg_frame_len = 16'd3;
   logic [31:0] s_axis_tdata = 32'd0;
   logic        s_axis_tvalid = 1'b0;
   logic        s_axis_tready;
   logic [31:0] m_axis_tdata;
   logic        m_axis_tvalid;
   logic        m_axis_tready = 1'b1;
   logic        m_axis_tlast;
   logic        m_axis_tuser;
   logic        frame_start;
   logic        null_too_long;
   logic [1:0]  sync_state;
`ifdef NSD_SEQ_STATS_EN
   logic [31:0] stat_frames;
   logic [15:0] stat_losses;
`endif

   null_symbol_frame_sequencer #(.LEN_W(16)) dut (
      .ACLK          (ACLK),
      .ARESET        (ARESET),
      .enable        (enable),
      .cfg_threshold (cfg_threshold),
      .cfg_min_null  (cfg_min_null),
      .cfg_max_null  (cfg_max_null),
      .cfg_frame_len (cfg_frame_len),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tuser  (m_axis_tuser),
      .frame_start   (frame_start),
      .null_too_long (null_too_long),
      .sync_state    (sync_state)
`ifdef NSD_SEQ_STATS_EN
      ,
      .stat_frames   (stat_frames),
      .stat_losses   (stat_losses)
`endif
   );

   always #5 ACLK = ~ACLK;

   int n_checks = 0;
   int n_errors = 0;

   function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end
   endfunction

   // Reference model: mode 0/1/2 = search/null/frame, one pending output slot.
   int          md = 0, run = 0, flen = 0, fidx = 0;
   bit          ob_v = 0, ob_u = 0, ob_l = 0, p_fs = 0, p_ntl = 0;
   logic [31:0] ob_d = 32'd0;

   typedef struct {
      logic [31:0] d;
      bit          u;
      bit          l;
   } beat_t;
   beat_t got[$];
   int    fs_cnt = 0, ntl_cnt = 0;
   bit    left_search = 0;

   function automatic int iabs(logic [15:0] x);
      int v;
      v = int'($signed(x));
      return (v < 0) ? -v : v;
   endfunction

   // One clock: drive, compare against the model, advance the model, move to the next negedge.
   task automatic step(input bit en, input bit sv, input logic [31:0] sd, input bit mr,
                       input bit rst);
      bit    exp_rdy, acc, low, fwd, f_u, f_l;
      int    mn_e, fl_e;
      beat_t b;
      ARESET = rst; enable = en; s_axis_tvalid = sv; s_axis_tdata = sd; m_axis_tready = mr;
      #1;
      exp_rdy = !rst && (md != 2 || !ob_v || mr);
      chk("s_tready", 32'(s_axis_tready), 32'(exp_rdy));
      chk("m_tvalid", 32'(m_axis_tvalid), 32'(ob_v));
      if (ob_v) begin
         chk("m_tdata", m_axis_tdata, ob_d);
         chk("m_tuser", 32'(m_axis_tuser), 32'(ob_u));
         chk("m_tlast", 32'(m_axis_tlast), 32'(ob_l));
      end
      chk("frame_start", 32'(frame_start), 32'(p_fs));
      chk("null_too_long", 32'(null_too_long), 32'(p_ntl));
      chk("sync_state", 32'(sync_state), 32'(md));
      if (m_axis_tvalid && mr) begin
         b.d = m_axis_tdata; b.u = m_axis_tuser; b.l = m_axis_tlast;
         got.push_back(b);
      end
      if (frame_start) fs_cnt++;
      if (null_too_long) ntl_cnt++;
      if (sync_state != 2'd0) left_search = 1;

      if (rst) begin
         md = 0; run = 0; ob_v = 0; ob_u = 0; ob_l = 0; ob_d = 32'd0; p_fs = 0; p_ntl = 0;
      end else begin
         acc  = sv && exp_rdy;
         low  = (iabs(sd[31:16]) + iabs(sd[15:0])) < int'(cfg_threshold);
         mn_e = (cfg_min_null == 16'd0) ? 1 : int'(cfg_min_null);
         fl_e = (cfg_frame_len == 16'd0) ? 1 : int'(cfg_frame_len);
         fwd = 0; f_u = 0; f_l = 0; p_fs = 0; p_ntl = 0;
         case (md)
            0: begin
               if (!en) run = 0;
               else begin
                  if (acc) run = low ? run + 1 : 0;
                  if (run >= mn_e) md = 1;
               end
            end
            1: begin
               if (!en) begin
                  md = 0; run = 0;
               end else if (acc) begin
                  if (low) run++;
                  else if (run <= int'(cfg_max_null)) begin
                     fwd = 1; f_u = 1; p_fs = 1; f_l = (fl_e == 1);
                     if (f_l) begin md = 0; run = 0; end
                     else begin md = 2; flen = fl_e; fidx = 1; end
                  end else begin
                     p_ntl = 1; run = 0; md = 0;
                  end
               end
            end
            default: begin
               if (acc) begin
                  fwd = 1; f_l = (fidx == flen - 1); fidx++;
                  if (f_l) begin md = 0; run = 0; end
               end
            end
         endcase
         if (fwd) begin
            ob_v = 1; ob_d = sd; ob_u = f_u; ob_l = f_l;
         end else if (mr) begin
            ob_v = 0;
         end
      end
      @(negedge ACLK);
   endtask

   task automatic feed_n(input int n, input logic [31:0] d);
      repeat (n) step(1, 1, d, 1, 0);
   endtask

   task automatic idle(input int n);
      repeat (n) step(1, 0, 32'd0, 1, 0);
   endtask

   task automatic do_reset();
      repeat (2) step(0, 0, 32'd0, 1, 1);
      idle(1);
   endtask

   task automatic clear_log();
      got.delete(); fs_cnt = 0; ntl_cnt = 0; left_search = 0;
   endtask

   task automatic chk_beat(string nm, int idx, logic [31:0] d, bit u, bit l);
      if (idx < got.size()) begin
         chk({nm, "_data"}, got[idx].d, d);
         chk({nm, "_tuser"}, 32'(got[idx].u), 32'(u));
         chk({nm, "_tlast"}, 32'(got[idx].l), 32'(l));
      end else begin
         chk({nm, "_count"}, 32'(got.size()), 32'(idx + 1));
      end
   endtask

   typedef struct {
      logic [31:0] d;
      logic [16:0] thr;
      int          exp_st;
   } vec_t;
   vec_t tbl[10];

   initial begin
      tbl[0] = '{32'h00000000, 17'd1,     1};
      tbl[1] = '{32'h00000000, 17'd0,     0};
      tbl[2] = '{32'h00630000, 17'd100,   1};
      tbl[3] = '{32'h00640000, 17'd100,   0};
      tbl[4] = '{32'hFF9D0000, 17'd100,   1};
      tbl[5] = '{32'h0032FFCE, 17'd100,   0};
      tbl[6] = '{32'h0032FFCF, 17'd100,   1};
      tbl[7] = '{32'h80008000, 17'd65535, 0};
      tbl[8] = '{32'h80008000, 17'h1FFFF, 1};
      tbl[9] = '{32'h7FFF7FFF, 17'd65535, 1};

      @(negedge ACLK);
      repeat (2) step(0, 0, 32'd0, 1, 1);
      chk("rst_s_tready", 32'(s_axis_tready), 32'd0);
      chk("rst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
      chk("rst_m_tdata", m_axis_tdata, 32'd0);
      chk("rst_flags", {28'd0, m_axis_tlast, m_axis_tuser, frame_start, null_too_long}, 32'd0);
      chk("rst_state", 32'(sync_state), 32'd0);
      idle(1);
      chk("post_rst_s_tready", 32'(s_axis_tready), 32'd1);

      // Magnitude classification: a low sample with min=1 moves to NULL.
      cfg_min_null = 16'd1;
      for (int i = 0; i < 10; i++) begin
         cfg_threshold = tbl[i].thr;
         do_reset();
         step(1, 1, tbl[i].d, 1, 0);
         idle(1);
         chk($sformatf("class%0d", i), 32'(sync_state), 32'(tbl[i].exp_st));
      end

      cfg_threshold = 17'd100; cfg_min_null = 16'd4; cfg_max_null = 16'd8; cfg_frame_len = 16'd3;
      do_reset();

      clear_log();
      feed_n(10, 32'h03E803E8); feed_n(5, 32'd0);
      feed_n(1, 32'h00C80000); feed_n(1, 32'h00C90000); feed_n(1, 32'h00CA0000);
      idle(3);
      chk("s1_beats", 32'(got.size()), 32'd3);
      chk_beat("s1_b0", 0, 32'h00C80000, 1, 0);
      chk_beat("s1_b1", 1, 32'h00C90000, 0, 0);
      chk_beat("s1_b2", 2, 32'h00CA0000, 0, 1);
      chk("s1_frame_start", 32'(fs_cnt), 32'd1);
      chk("s1_state", 32'(sync_state), 32'd0);
`ifdef NSD_SEQ_STATS_EN
      chk("s1_stat_frames", stat_frames, 32'd1);
`endif

      clear_log();
      feed_n(9, 32'd0); feed_n(1, 32'h03E803E8); idle(2);
      chk("s2_ntl", 32'(ntl_cnt), 32'd1);
      chk("s2_beats", 32'(got.size()), 32'd0);
      chk("s2_state", 32'(sync_state), 32'd0);

      clear_log();
      feed_n(3, 32'd0); feed_n(1, 32'h03E803E8); idle(2);
      chk("s3_left_search", 32'(left_search), 32'd0);
      chk("s3_beats", 32'(got.size()), 32'd0);

      clear_log();
      feed_n(10, 32'h03E803E8); feed_n(5, 32'd0); feed_n(1, 32'h00C80000);
      for (int k = 0; k < 5; k++) begin
         step(1, 1, 32'h00C90000, 0, 0);
         chk("bp_s_tready", 32'(s_axis_tready), 32'd0);
         chk("bp_hold_data", m_axis_tdata, 32'h00C80000);
         chk("bp_hold_tuser", 32'(m_axis_tuser), 32'd1);
      end
      step(1, 1, 32'h00C90000, 1, 0); step(1, 1, 32'h00CA0000, 1, 0); idle(3);
      chk("bp_beats", 32'(got.size()), 32'd3);
      chk_beat("bp_b0", 0, 32'h00C80000, 1, 0);
      chk_beat("bp_b1", 1, 32'h00C90000, 0, 0);
      chk_beat("bp_b2", 2, 32'h00CA0000, 0, 1);

      cfg_frame_len = 16'd0;
      clear_log();
      feed_n(4, 32'd0); feed_n(1, 32'h00C80000); idle(3);
      chk("len0_beats", 32'(got.size()), 32'd1);
      chk_beat("len0_b0", 0, 32'h00C80000, 1, 1);
      chk("len0_frame_start", 32'(fs_cnt), 32'd1);
      cfg_frame_len = 16'd3;

      clear_log();
      feed_n(10, 32'h03E803E8); feed_n(5, 32'd0);
      feed_n(1, 32'h00C80000); feed_n(1, 32'h00C90000);
      step(1, 1, 32'h00CA0000, 0, 1);
      chk("mrst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
      chk("mrst_m_tdata", m_axis_tdata, 32'd0);
      chk("mrst_tlast", 32'(m_axis_tlast), 32'd0);
      chk("mrst_state", 32'(sync_state), 32'd0);
`ifdef NSD_SEQ_STATS_EN
      chk("mrst_stat_frames", stat_frames, 32'd0);
`endif
      idle(2);
      chk("mrst_beats", 32'(got.size()), 32'd1);

      // Randomized traffic; the tlast beat is never stalled so the next frame cannot collide.
      for (int r = 0; r < 4; r++) begin
         cfg_min_null  = 16'($urandom_range(0, 4));
         cfg_max_null  = 16'($urandom_range(0, 8));
         cfg_frame_len = 16'($urandom_range(0, 4));
         do_reset();
         for (int c = 0; c < 600; c++) begin
            logic [31:0] d;
            bit          mr;
            d = $urandom;
            if ($urandom_range(0, 9) < 6)
               d = {{10{d[31]}}, d[21:16], {10{d[15]}}, d[5:0]};
            mr = (ob_v && ob_l) ? 1'b1 : ($urandom_range(0, 2) != 0);
            step($urandom_range(0, 49) != 0, $urandom_range(0, 3) != 0, d, mr, 0);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
